counter_ctrl_seq: RTL and testbench
===================================

COUNTER_CTRL_SEQ -- requirements
Module: counter_ctrl_seq

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 cs_n  input  1  chip select, active low.
REQ-005 rd_n  input  1  read strobe, active low.
REQ-006 wr_n  input  1  write strobe, active low.
REQ-007 a1, a0  input  1 each  address: 00/01/10 = counter 0/1/2, 11 = control word.
REQ-008 din  input  8  bus write data.
REQ-009 count0, count1, count2  input  16 each  live count value from each counter.
REQ-010 dout  output  8  registered read data.
REQ-011 dout_en  output  1  registered; high while the read data in dout is valid.
REQ-012 load_val  output  16  registered initial count for the counter being loaded.
REQ-013 load_stb  output  3  one-hot, one-cycle pulse; bit i = load counter i with load_val.
REQ-014 mode0, mode1, mode2  output  3 each  programmed mode per counter.
REQ-015 bcd  output  3  bit i = counter i counts BCD.

Function
REQ-016 SHALL register rd_n and wr_n each cycle (rd_q, wr_q); write event = wr_q=1, wr_n=0, cs_n=0; read event = rd_q=1, rd_n=0, cs_n=0.
REQ-017 SHALL keep per counter: rw[1:0], mode[2:0], bcd, write-byte pointer wp, read-byte pointer rp, lsb holding byte, latched flag, 16-bit latch.
REQ-018 Control write (addr 11): SC=din[7:6], RW=din[5:4], M=din[3:1], BCD=din[0].
REQ-019 SC=11 (read-back) SHALL be ignored; no state change.
REQ-020 RW=00 SHALL latch count[SC] into latch[SC] and set latched, only if latched is clear; mode/rw unchanged.
REQ-021 RW!=00 SHALL set rw, mode (M=11x stored as 01x), bcd for counter SC; clear wp, rp, latched.
REQ-022 Data write to counter i with rw=00 (unprogrammed) SHALL be ignored.
REQ-023 rw=01: load_val={8'h00,din}, pulse load_stb[i]; rw=10: load_val={din,8'h00}, pulse load_stb[i].
REQ-024 rw=11: wp=0 stores din as lsb, sets wp=1, no strobe; wp=1 gives load_val={din,lsb}, pulses load_stb[i], clears wp.
REQ-025 load_stb SHALL be high exactly the one cycle after the edge that detected the write event; load_val valid in that same cycle and held until next load.
REQ-026 Read source SHALL be latch[i] if latched, else count[i] sampled at the detecting edge.
REQ-027 rw=01 returns low byte; rw=10 returns high byte; rw=11 returns low byte if rp=0 (set rp=1), high byte if rp=1 (clear rp).
REQ-028 latched SHALL clear after the final byte of a read (single byte for rw 01/10, high byte for rw 11).
REQ-029 dout SHALL update the cycle after the read event; dout_en SHALL rise then and fall the cycle after rd_n or cs_n goes high.
REQ-030 Read at addr 11 or of an unprogrammed counter: dout_en stays 0, no pointer change.
REQ-031 Read and write events in the same cycle: write executes, read ignored.
REQ-032 Control word to counter i mid-sequence SHALL abandon the pending byte (wp/rp cleared, no strobe).
REQ-033 Other counters' state SHALL be unaffected by any access to counter i.

Reset
REQ-034 On reset: rw=00, mode=000, bcd=0, wp=rp=0, latched=0 for all counters; dout=8'h00, dout_en=0, load_val=16'h0000, load_stb=000, rd_q=wr_q=1.
REQ-035 Reset asserted mid-sequence SHALL discard pending lsb and any latch; no strobe issued.

Verification
REQ-036 Ctrl 8'h34 (ctr0, rw=11, mode 2), write 8'h10 then 8'h27 to addr 00 -> single load_stb=001 with load_val=16'h2710 after second write only; mode0=010.
REQ-037 Ctrl 8'h56 (ctr1, rw=01, mode 3), write 8'h0A to addr 01 -> load_stb=010, load_val=16'h000A; mode1=011.
REQ-038 Ctr2 rw=11, count2=16'hABCD, ctrl 8'h80 (latch), count2 changes to 16'h1234, two reads of addr 10 -> dout 8'hCD then 8'hAB; third/fourth reads -> 8'h34, 8'h12.
REQ-039 Ctrl 8'h3E (M=111) -> mode0=011; ctrl 8'hF0 (read-back) -> no output change.
REQ-040 Ctr0 rw=11, write 8'h55 only, then ctrl 8'h30, write 8'h01, 8'h02 -> one strobe, load_val=16'h0201.
REQ-041 Assert reset after first byte of two-byte load -> all outputs at reset values; subsequent data writes ignored (rw=00).

Source files
------------

// File: rtl/counter_ctrl_seq.sv
// counter_ctrl_seq: bus-side control for a three-counter timer.
// Decodes control words, assembles load values, latches counts and serves byte reads.
module counter_ctrl_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        a1,
    input  logic        a0,
    input  logic [7:0]  din,
    input  logic [15:0] count0,
    input  logic [15:0] count1,
    input  logic [15:0] count2,
    output logic [7:0]  dout,
    output logic        dout_en,
    output logic [15:0] load_val,
    output logic [2:0]  load_stb,
    output logic [2:0]  mode0,
    output logic [2:0]  mode1,
    output logic [2:0]  mode2,
    output logic [2:0]  bcd
);
    logic        r_rd_q, r_wr_q;
    logic [1:0]  r_rw [3];
    logic [2:0]  r_mode [3];
    logic [7:0]  r_lsb [3];
    logic [15:0] r_latch [3];
    logic [2:0]  r_bcd, r_wp, r_rp, r_latched;
    logic [7:0]  r_dout;
    logic        r_dout_en;
    logic [15:0] r_load_val;
    logic [2:0]  r_load_stb;
    logic [1:0]  w_addr;
    logic        w_wr, w_rd, w_ctl;
    logic [2:0]  w_mode_in;
    logic [15:0] w_count [3];
    logic [15:0] w_src [3];

    assign w_addr    = {a1, a0};
    assign w_wr      = r_wr_q && !wr_n && !cs_n;
    assign w_rd      = r_rd_q && !rd_n && !cs_n && !w_wr;
    assign w_ctl     = w_wr && w_addr == 2'b11;
    // modes 6 and 7 alias to 2 and 3
    assign w_mode_in = (din[3:2] == 2'b11) ? {1'b0, din[2:1]} : din[3:1];
    assign w_count   = '{count0, count1, count2};

    for (genvar g = 0; g < 3; g++) begin : g_src
        assign w_src[g] = r_latched[g] ? r_latch[g] : w_count[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_q     <= 1'b1;
            r_wr_q     <= 1'b1;
            r_bcd      <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_latched  <= '0;
            r_dout     <= '0;
            r_dout_en  <= 1'b0;
            r_load_val <= '0;
            r_load_stb <= '0;
            for (int i = 0; i < 3; i++) begin
                r_rw[i]    <= '0;
                r_mode[i]  <= '0;
                r_lsb[i]   <= '0;
                r_latch[i] <= '0;
            end
        end else begin
            r_rd_q     <= rd_n;
            r_wr_q     <= wr_n;
            r_load_stb <= '0;
            if (rd_n || cs_n)
                r_dout_en <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (w_ctl && din[7:6] == 2'(i)) begin
                    if (din[5:4] == 2'b00) begin
                        if (!r_latched[i]) begin
                            r_latch[i]   <= w_count[i];
                            r_latched[i] <= 1'b1;
                        end
                    end else begin
                        r_rw[i]      <= din[5:4];
                        r_mode[i]    <= w_mode_in;
                        r_bcd[i]     <= din[0];
                        r_wp[i]      <= 1'b0;
                        r_rp[i]      <= 1'b0;
                        r_latched[i] <= 1'b0;
                    end
                end else if (w_wr && w_addr == 2'(i) && r_rw[i] != 2'b00) begin
                    if (r_rw[i] == 2'b11 && !r_wp[i]) begin
                        r_lsb[i] <= din;
                        r_wp[i]  <= 1'b1;
                    end else begin
                        r_load_val    <= (r_rw[i] == 2'b01) ? {8'h00, din} :
                                         (r_rw[i] == 2'b10) ? {din, 8'h00} : {din, r_lsb[i]};
                        r_load_stb[i] <= 1'b1;
                        r_wp[i]       <= 1'b0;
                    end
                end else if (w_rd && w_addr == 2'(i) && r_rw[i] != 2'b00) begin
                    r_dout    <= (r_rw[i] == 2'b10 || (r_rw[i] == 2'b11 && r_rp[i])) ?
                                 w_src[i][15:8] : w_src[i][7:0];
                    r_dout_en <= 1'b1;
                    r_rp[i]   <= r_rw[i] == 2'b11 && !r_rp[i];
                    if (r_rw[i] != 2'b11 || r_rp[i])
                        r_latched[i] <= 1'b0;
                end
            end
        end
    end

    assign dout     = r_dout;
    assign dout_en  = r_dout_en;
    assign load_val = r_load_val;
    assign load_stb = r_load_stb;
    assign mode0    = r_mode[0];
    assign mode1    = r_mode[1];
    assign mode2    = r_mode[2];
    assign bcd      = r_bcd;
endmodule

// File: tb/tb_counter_ctrl_seq.sv
// tb_counter_ctrl_seq: scoreboard bench with a transaction-level reference model.
module tb_counter_ctrl_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a1 = 1'b0, a0 = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [15:0] cnt [3];
    logic [7:0]  dout;
    logic        dout_en;
    logic [15:0] load_val;
    logic [2:0]  load_stb, mode0, mode1, mode2, bcd;

    counter_ctrl_seq dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .a1(a1), .a0(a0), .din(din),
        .count0(cnt[0]), .count1(cnt[1]), .count2(cnt[2]),
        .dout(dout), .dout_en(dout_en), .load_val(load_val), .load_stb(load_stb),
        .mode0(mode0), .mode1(mode1), .mode2(mode2), .bcd(bcd)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0;
    logic [18:0] lq [$];
    logic [7:0]  rq [$];
    int m_rw [3], m_mode [3], m_lsb [3], m_lval [3];
    bit m_bcd [3], m_have [3], m_hi [3], m_lv [3];
    int m_last_load;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rw[i] = 0; m_mode[i] = 0; m_lsb[i] = 0; m_lval[i] = 0;
            m_bcd[i] = 0; m_have[i] = 0; m_hi[i] = 0; m_lv[i] = 0;
        end
        m_last_load = 0;
        lq.delete();
        rq.delete();
    endtask

    task automatic push_load(input int a, input int v);
        lq.push_back({3'(1 << a), 16'(v)});
        m_last_load = v;
    endtask

    task automatic model_write(input int a, input int d);
        int sc, rwf, m;
        if (a == 3) begin
            sc = d / 64; rwf = (d / 16) % 4; m = (d / 2) % 8;
            if (sc == 3) return;
            if (rwf == 0) begin
                if (!m_lv[sc]) begin m_lv[sc] = 1; m_lval[sc] = int'(cnt[sc]); end
            end else begin
                m_rw[sc] = rwf; m_mode[sc] = (m >= 6) ? m - 4 : m; m_bcd[sc] = bit'(d % 2);
                m_have[sc] = 0; m_hi[sc] = 0; m_lv[sc] = 0;
            end
        end else if (m_rw[a] == 1) push_load(a, d);
        else if (m_rw[a] == 2) push_load(a, d * 256);
        else if (m_rw[a] == 3) begin
            if (m_have[a]) begin push_load(a, d * 256 + m_lsb[a]); m_have[a] = 0; end
            else begin m_lsb[a] = d; m_have[a] = 1; end
        end
    endtask

    task automatic model_read(input int a);
        int v;
        bit hi;
        if (a == 3 || m_rw[a] == 0) return;
        v  = m_lv[a] ? m_lval[a] : int'(cnt[a]);
        hi = m_rw[a] == 2 || (m_rw[a] == 3 && m_hi[a]);
        rq.push_back(8'(hi ? v / 256 : v % 256));
        if (m_rw[a] == 3) m_hi[a] = !m_hi[a];
        if (m_rw[a] != 3 || hi) m_lv[a] = 0;
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        {a1, a0} = 2'(a); din = 8'(d); cs_n = 1'b0; wr_n = 1'b0;
        model_write(a, d % 256);
        @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
    endtask

    task automatic rd(input int a);
        @(negedge clk);
        {a1, a0} = 2'(a); cs_n = 1'b0; rd_n = 1'b0;
        model_read(a);
        @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1;
    endtask

    task automatic both(input int a, input int d);
        @(negedge clk);
        {a1, a0} = 2'(a); din = 8'(d); cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        model_write(a, d % 256);
        @(negedge clk);
        rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
    endtask

    task automatic check_regs();
        chk("mode0", 32'(mode0), 32'(m_mode[0]));
        chk("mode1", 32'(mode1), 32'(m_mode[1]));
        chk("mode2", 32'(mode2), 32'(m_mode[2]));
        chk("bcd", 32'(bcd), {29'd0, m_bcd[2], m_bcd[1], m_bcd[0]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_en", 32'(dout_en), 0);
        chk("rst_load_val", 32'(load_val), 0);
        chk("rst_load_stb", 32'(load_stb), 0);
        check_regs();
        reset = 1'b0;
    endtask

    // monitor: every strobe or rising dout_en must match the oldest expectation
    bit prev_en = 0;
    logic [18:0] exp_l;
    always @(negedge clk) begin
        if (reset) prev_en = 0;
        else begin
            if (load_stb != 3'b000) begin
                if (lq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_load: got stb %b val %h expected none", load_stb, load_val);
                end else begin
                    exp_l = lq.pop_front();
                    chk("load_stb", 32'(load_stb), 32'(exp_l[18:16]));
                    chk("load_val", 32'(load_val), 32'(exp_l[15:0]));
                end
            end
            if (dout_en && !prev_en) begin
                if (rq.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_read: got dout %h expected none", dout);
                end else chk("dout", 32'(dout), 32'(rq.pop_front()));
            end
            prev_en = dout_en;
        end
    end

    initial begin
        int r, a;
        for (int i = 0; i < 3; i++) cnt[i] = 16'($urandom);
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_dout_en", 32'(dout_en), 0);
        chk("init_load_stb", 32'(load_stb), 0);
        do_reset();
        // two-byte load on counter 0
        wr(3, 'h34); check_regs(); wr(0, 'h10); wr(0, 'h27);
        repeat (3) @(negedge clk);
        chk("load_val_hold", 32'(load_val), 32'h2710);
        // single-byte load on counter 1
        wr(3, 'h56); check_regs(); wr(1, 'h0A);
        // latched read on counter 2, then live reads
        wr(3, 'hB0); check_regs();
        @(negedge clk); cnt[2] = 16'hABCD;
        wr(3, 'h80);
        @(negedge clk); cnt[2] = 16'h1234;
        repeat (4) rd(2);
        // mode aliasing and ignored read-back command
        wr(3, 'h3E); chk("mode_alias", 32'(mode0), 3);
        wr(3, 'hF0); check_regs();
        // control word abandons a pending lsb
        wr(3, 'h30); wr(0, 'h55); wr(3, 'h30); wr(0, 'h01); wr(0, 'h02);
        // simultaneous read and write: write wins
        both(0, 'h99); both(0, 'h88); rd(0); rd(0);
        // reset in the middle of a two-byte load
        wr(3, 'h34); wr(0, 'h10);
        do_reset();
        wr(0, 'h27); rd(0); rd(3);
        repeat (2) @(negedge clk);
        chk("post_rst_load_val", 32'(load_val), 0);
        chk("post_rst_mode0", 32'(mode0), 0);
        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 2);
            if (r < 2) begin wr(3, $urandom_range(0, 255)); check_regs(); end
            else if (r < 5) wr(a, $urandom_range(0, 255));
            else if (r < 8) rd($urandom_range(0, 3));
            else if (r == 8) both(a, $urandom_range(0, 255));
            else begin @(negedge clk); cnt[a] = 16'($urandom); end
        end
        repeat (4) @(negedge clk);
        check_regs();
        chk("load_last", 32'(load_val), 32'(16'(m_last_load)));
        chk("loads_drained", 32'(lq.size()), 0);
        chk("reads_drained", 32'(rq.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
